tt_um_hoene_protocol_decoder: RTL and testbench
===============================================

Name: tt_um_hoene_protocol_decoder

Overview:
- Smart-LED serial protocol decoder; sits directly downstream of tt_um_hoene_low_pass_filter and consumes its filtered, clock-synchronous output.
- Measures high-pulse widths and classifies each pulse as a 0 or 1 bit.
- Assembles the first WORD_BITS bits after a latch into a colour word, then forwards all later traffic to the next LED in the chain until the next latch (reset) period.

Parameters:
CNT_W, 8, width of the saturating high/low pulse counters
WORD_BITS, 24, bits per LED colour word, MSB first
T_MIN_HIGH, 2, high pulses shorter than this many cycles are ignored as glitches
T_BIT_THRESHOLD, 12, high width >= this decodes as 1, otherwise 0
T_RESET, 100, consecutive low cycles that constitute a latch
T_MAX_HIGH, 40, high width above this is an error (optional feature only)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in  input  1  filtered serial line from the low-pass filter
dout  output  1  forwarded serial stream to the next LED
data  output  WORD_BITS  last complete colour word
data_valid  output  1  one-cycle strobe: data updated
bit_valid  output  1  one-cycle strobe per decoded bit
bit_value  output  1  decoded bit, valid with bit_valid
latch  output  1  one-cycle strobe when a latch period is detected
error  output  1  sticky pulse-width error (optional feature, else 0)

Behaviour:
- Reset: clk and rst_n as named; reset is asynchronous, active-low.
  - All outputs are 0 and the shift register is 0.
  - bit_count = 0, prev_in = 0, both counters = 0, state = RECEIVE.
  - Asserting reset mid-word or mid-forward discards everything immediately.
- Edge detection:
  - prev_in is a register holding the previous sample of in.
  - Cycle F is the cycle where in = 0 and prev_in = 1 (falling edge).
- Counters:
  - high_cnt counts consecutive samples with in = 1 and clears on the first 0 sample.
  - low_cnt counts consecutive samples with in = 0 and clears on the first 1 sample.
  - Both counters saturate at 2^CNT_W-1 and never wrap.
- Bit decode at cycle F (registered outputs):
  - If high_cnt < T_MIN_HIGH: the pulse is ignored; no strobe, no state change.
  - Otherwise, in cycle F+1: bit_valid = 1 and bit_value = (high_cnt >= T_BIT_THRESHOLD).
  - Bits decode only in state RECEIVE. In FORWARD, no bit_valid is produced.
- State RECEIVE:
  - Each decoded bit is shifted into the LSB of the shift register and bit_count increments.
  - On the WORD_BITS-th bit, in cycle F+1:
    - data = full shift register and data_valid = 1, coincident with that bit's bit_valid.
    - bit_count = 0 and state becomes FORWARD.
  - dout = 0 throughout.
- State FORWARD:
  - dout = prev_in, a one-cycle delayed copy of in.
  - Forwarding starts with the first sample after the transition. The tail of the final word bit is not forwarded.
- Latch:
  - When low_cnt reaches exactly T_RESET: latch = 1 in the next cycle, once per low period.
  - Latch clears bit_count and discards a partial word, with no data_valid.
  - Latch forces state to RECEIVE, so dout = 0 from the latch cycle on.
  - data holds its value across a latch.
- Simultaneity:
  - A word completion and a latch cannot coincide, because a falling edge resets low_cnt.
  - An input glitch during a low period restarts the latch count.
- The state encoding is exactly two states: RECEIVE and FORWARD.

Optional Feature:
- Macro: HOENE_DECODER_ERROR_DETECT_EN.
- Defined:
  - error sets in cycle F+1 if a pulse had high_cnt < T_MIN_HIGH or high_cnt > T_MAX_HIGH.
  - error stays set until the next latch strobe clears it. A latch and a new error in the same cycle leave error = 1.
  - Over-long pulses still decode as 1.
- Undefined: error is tied to 0 and no comparator against T_MAX_HIGH exists. Decoding is identical in both builds.

Decomposition:
- Package tt_um_hoene_pkg holds:
  - the state enum (RECEIVE, FORWARD);
  - default timing constants (T_MIN_HIGH, T_BIT_THRESHOLD, T_RESET, T_MAX_HIGH, WORD_BITS).
- Sub-module tt_um_hoene_pulse_timer contains:
  - the prev_in register and the rise/fall edge strobes;
  - the saturating high_cnt and low_cnt counters.
- The top module keeps the FSM, shift register, outputs and error logic.

Test Plan:
- Reset then 24 pulses encoding 0xA5C3F0 (1 = 20 cycles high, 0 = 6 cycles high, 30-cycle bit period) -> 24 bit_valid strobes with the matching values; data = 0xA5C3F0 with data_valid coincident with the 24th bit_valid; state FORWARD.
- Same word followed immediately by a second word 0x123456 -> data stays 0xA5C3F0; dout reproduces the second word's waveform delayed by 1 cycle; no bit_valid.
- 10 bits then 100 low cycles -> latch pulses once at low-cycle 101; no data_valid; next 24 bits produce a new word from bit 0.
- 1-cycle high glitches mixed into a word -> ignored, word decodes correctly. With HOENE_DECODER_ERROR_DETECT_EN, error = 1 until the next latch.
- 50-cycle high pulse with the macro defined -> bit_value = 1 and error = 1. Without the macro, error stays 0.
- Assert rst_n low mid-forward, at word bit 12 -> all outputs 0 immediately; after release, a fresh 24-bit word decodes from the first pulse.

Source files
------------

// File: rtl/tt_um_hoene_pkg.sv
// rtl/tt_um_hoene_pkg.sv - shared state type and default timing for the smart-LED decoder
package tt_um_hoene_pkg;

   typedef enum logic [0:0] {
      RECEIVE = 1'b0,
      FORWARD = 1'b1
   } state_e;

   localparam int DEF_CNT_W           = 8;
   localparam int DEF_WORD_BITS       = 24;
   localparam int DEF_T_MIN_HIGH      = 2;
   localparam int DEF_T_BIT_THRESHOLD = 12;
   localparam int DEF_T_RESET         = 100;
   localparam int DEF_T_MAX_HIGH      = 40;

endpackage

// File: rtl/tt_um_hoene_pulse_timer.sv
// rtl/tt_um_hoene_pulse_timer.sv - line edge detection and saturating high/low run counters
module tt_um_hoene_pulse_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in,
   output logic             prev_in,
   output logic             fall,
   output logic [CNT_W-1:0] high_cnt,
   output logic [CNT_W-1:0] low_cnt,
   output logic [CNT_W-1:0] low_cnt_nxt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             prev_in_q, prev_in_d;
   logic             rise;
   logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
   logic [CNT_W-1:0] low_cnt_q, low_cnt_d;

   always_comb begin
      rise       = in & ~prev_in_q;
      fall       = ~in & prev_in_q;
      prev_in_d  = in;
      high_cnt_d = '0;
      low_cnt_d  = '0;
      // each counter restarts at 1 on the edge that opens its run
      if (in) begin
         if (rise)
            high_cnt_d = CNT_W'(1);
         else
            high_cnt_d = (high_cnt_q == CNT_MAX) ? CNT_MAX : high_cnt_q + CNT_W'(1);
      end else begin
         if (fall)
            low_cnt_d = CNT_W'(1);
         else
            low_cnt_d = (low_cnt_q == CNT_MAX) ? CNT_MAX : low_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_in_q  <= 1'b0;
         high_cnt_q <= '0;
         low_cnt_q  <= '0;
      end else begin
         prev_in_q  <= prev_in_d;
         high_cnt_q <= high_cnt_d;
         low_cnt_q  <= low_cnt_d;
      end
   end

   assign prev_in     = prev_in_q;
   assign high_cnt    = high_cnt_q;
   assign low_cnt     = low_cnt_q;
   assign low_cnt_nxt = low_cnt_d;

endmodule

// File: rtl/tt_um_hoene_protocol_decoder.sv
// rtl/tt_um_hoene_protocol_decoder.sv - smart-LED decoder: bit classify, word capture, forward, latch
// Optional sticky pulse-width error flag enabled by defining HOENE_DECODER_ERROR_DETECT_EN.
module tt_um_hoene_protocol_decoder
   import tt_um_hoene_pkg::*;
#(
   parameter int CNT_W           = DEF_CNT_W,
   parameter int WORD_BITS       = DEF_WORD_BITS,
   parameter int T_MIN_HIGH      = DEF_T_MIN_HIGH,
   parameter int T_BIT_THRESHOLD = DEF_T_BIT_THRESHOLD,
`ifdef HOENE_DECODER_ERROR_DETECT_EN
   parameter int T_MAX_HIGH      = DEF_T_MAX_HIGH,
`endif
   parameter int T_RESET         = DEF_T_RESET
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in,
   output logic                 dout,
   output logic [WORD_BITS-1:0] data,
   output logic                 data_valid,
   output logic                 bit_valid,
   output logic                 bit_value,
   output logic                 latch,
   output logic                 error
);

   localparam int              BC_W     = $clog2(WORD_BITS);
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_BITS - 1);

   logic             prev_in, fall;
   logic [CNT_W-1:0] high_cnt, low_cnt, low_cnt_nxt;

   tt_um_hoene_pulse_timer #(.CNT_W(CNT_W)) u_timer (
      .clk         (clk),
      .rst_n       (rst_n),
      .in          (in),
      .prev_in     (prev_in),
      .fall        (fall),
      .high_cnt    (high_cnt),
      .low_cnt     (low_cnt),
      .low_cnt_nxt (low_cnt_nxt)
   );

   state_e               state_q, state_d;
   logic [WORD_BITS-1:0] shift_q, shift_d, data_q, data_d;
   logic [BC_W-1:0]      bit_count_q, bit_count_d;
   logic                 bit_valid_q, bit_valid_d, bit_value_q, bit_value_d;
   logic                 data_valid_q, data_valid_d, latch_q, latch_d;
   logic                 pulse_ok, pulse_one;

   always_comb begin
      pulse_ok     = fall && (high_cnt >= CNT_W'(T_MIN_HIGH));
      pulse_one    = high_cnt >= CNT_W'(T_BIT_THRESHOLD);
      // second term keeps a saturated counter from re-firing the latch
      latch_d      = (low_cnt_nxt == CNT_W'(T_RESET)) && (low_cnt != CNT_W'(T_RESET));
      state_d      = state_q;
      shift_d      = shift_q;
      data_d       = data_q;
      bit_count_d  = bit_count_q;
      bit_valid_d  = 1'b0;
      bit_value_d  = 1'b0;
      data_valid_d = 1'b0;
      if (latch_d) begin
         state_d     = RECEIVE;
         bit_count_d = '0;
         shift_d     = '0;
      end else if (pulse_ok && state_q == RECEIVE) begin
         bit_valid_d = 1'b1;
         bit_value_d = pulse_one;
         shift_d     = {shift_q[WORD_BITS-2:0], pulse_one};
         if (bit_count_q == LAST_BIT) begin
            data_d       = shift_d;
            data_valid_d = 1'b1;
            bit_count_d  = '0;
            state_d      = FORWARD;
         end else begin
            bit_count_d = bit_count_q + BC_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= RECEIVE;
         shift_q      <= '0;
         data_q       <= '0;
         bit_count_q  <= '0;
         bit_valid_q  <= 1'b0;
         bit_value_q  <= 1'b0;
         data_valid_q <= 1'b0;
         latch_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         data_q       <= data_d;
         bit_count_q  <= bit_count_d;
         bit_valid_q  <= bit_valid_d;
         bit_value_q  <= bit_value_d;
         data_valid_q <= data_valid_d;
         latch_q      <= latch_d;
      end
   end

`ifdef HOENE_DECODER_ERROR_DETECT_EN
   logic error_q, error_d, pulse_bad;

   always_comb begin
      pulse_bad = fall && ((high_cnt < CNT_W'(T_MIN_HIGH)) || (high_cnt > CNT_W'(T_MAX_HIGH)));
      error_d   = pulse_bad || (error_q && !latch_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         error_q <= 1'b0;
      else
         error_q <= error_d;
   end

   assign error = error_q;
`else
   assign error = 1'b0;
`endif

   assign dout       = (state_q == FORWARD) & prev_in;
   assign data       = data_q;
   assign data_valid = data_valid_q;
   assign bit_valid  = bit_valid_q;
   assign bit_value  = bit_value_q;
   assign latch      = latch_q;

endmodule

// File: tb/tb_tt_um_hoene_protocol_decoder.sv
// tb/tb_tt_um_hoene_protocol_decoder.sv - scoreboard bench for the smart-LED protocol decoder
module tb_tt_um_hoene_protocol_decoder;

   localparam int MAXS = 32768;

   typedef struct { int kind; int stamp; int val; } ev_t;   // kind: 0 bit, 1 word, 2 latch
   typedef struct { bit lvl; int len; } run_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        in    = 1'b0;
   logic        dout, data_valid, bit_valid, bit_value, latch, error;
   logic [23:0] data;

   always #5 clk = ~clk;

   tt_um_hoene_protocol_decoder dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in         (in),
      .dout       (dout),
      .data       (data),
      .data_valid (data_valid),
      .bit_valid  (bit_valid),
      .bit_value  (bit_value),
      .latch      (latch),
      .error      (error)
   );

   bit   samp     [MAXS];
   bit   exp_dout [MAXS];
   bit   exp_err  [MAXS];
   ev_t  evq [$];
   run_t runs [$];
   int   nsamp = 0, seg_first = 0, seg_last = 0;
   int   checks = 0, failures = 0;
   int   cur_idx = 0;
   bit   active = 1'b0;

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   task automatic take(input int kind, input int val, input int k);
      checks++;
      if (evq.size() == 0) begin
         failures++;
         $display("FAIL unexpected_event kind=%0d stamp=%0d got=%0h want=none", kind, k, val);
      end else if (evq[0].kind != kind || evq[0].stamp != k || evq[0].val != val) begin
         failures++;
         $display("FAIL event got kind=%0d stamp=%0d val=%0h want kind=%0d stamp=%0d val=%0h",
                  kind, k, val, evq[0].kind, evq[0].stamp, evq[0].val);
         if (evq[0].stamp == k) evq.delete(0);
      end else begin
         evq.delete(0);
      end
   endtask

   task automatic add_run(input bit lvl, input int len);
      run_t r;
      if (len > 0) begin
         if (runs.size() > 0 && runs[runs.size()-1].lvl == lvl) begin
            runs[runs.size()-1].len += len;
         end else begin
            r.lvl = lvl;
            r.len = len;
            runs.push_back(r);
         end
      end
   endtask

   task automatic add_bit(input bit v, input int hi1, input int hi0, input int period);
      int h;
      h = v ? hi1 : hi0;
      add_run(1'b1, h);
      add_run(1'b0, period - h);
   endtask

   task automatic add_std_bits(input logic [23:0] w, input int msb, input int lsb);
      for (int i = msb; i >= lsb; i--) add_bit(w[i], 20, 6, 30);
   endtask

   task automatic add_rand_word(input logic [23:0] w);
      int h;
      for (int i = 23; i >= 0; i--) begin
         h = w[i] ? int'($urandom_range(40, 12)) : int'($urandom_range(11, 2));
         add_run(1'b1, h);
         add_run(1'b0, int'($urandom_range(25, 3)));
      end
   endtask

   task automatic push_ev(input int kind, input int stamp, input int val);
      ev_t e;
      e.kind  = kind;
      e.stamp = stamp;
      e.val   = val;
      evq.push_back(e);
   endtask

   // Reference: walks the run list of one post-reset segment and derives events from pulse widths.
   task automatic run_model();
      int p, cnt, sr, prev_high, h;
      bit fwd, err, v;
      p = nsamp; cnt = 0; sr = 0; prev_high = 0; fwd = 1'b0; err = 1'b0;
      foreach (runs[r]) begin
         if (p + runs[r].len >= MAXS) begin
            $display("FAIL sample_buffer got=%0d want<%0d", p + runs[r].len, MAXS);
            $fatal(1);
         end
         if (runs[r].lvl) begin
            for (int i = 0; i < runs[r].len; i++) begin
               samp[p] = 1'b1; exp_dout[p] = fwd; exp_err[p] = err; p++;
            end
            prev_high = runs[r].len;
         end else begin
            if (prev_high > 0) begin
               h = (prev_high > 255) ? 255 : prev_high;
`ifdef HOENE_DECODER_ERROR_DETECT_EN
               if (h < 2 || h > 40) err = 1'b1;
`endif
               if (h >= 2 && !fwd) begin
                  v = (h >= 12);
                  push_ev(0, p, int'(v));
                  sr = ((sr << 1) | int'(v)) & 32'h00FF_FFFF;
                  cnt++;
                  if (cnt == 24) begin
                     push_ev(1, p, sr);
                     cnt = 0;
                     fwd = 1'b1;
                  end
               end
            end
            for (int i = 0; i < runs[r].len; i++) begin
               if (i == 99) begin
                  push_ev(2, p, 0);
                  fwd = 1'b0; cnt = 0; err = 1'b0;
               end
               samp[p] = 1'b0; exp_dout[p] = 1'b0; exp_err[p] = err; p++;
            end
            prev_high = 0;
         end
      end
      seg_first = nsamp;
      seg_last  = p - 1;
      nsamp     = p;
      runs.delete();
   endtask

   task automatic run_segment();
      run_model();
      active = 1'b0;
      in     = 1'b0;
      rst_n  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int g = seg_first; g <= seg_last; g++) begin
         if (g != seg_first) begin
            @(posedge clk);
            #1;
         end
         in = samp[g]; cur_idx = g; active = 1'b1;
      end
      @(posedge clk);
      #1;
      active = 1'b0;
      @(negedge clk);
      #1;
      chk("events_drained", evq.size(), 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_dout"}, int'(dout), 0);
      chk({tag, "_data"}, int'(data), 0);
      chk({tag, "_data_valid"}, int'(data_valid), 0);
      chk({tag, "_bit_valid"}, int'(bit_valid), 0);
      chk({tag, "_bit_value"}, int'(bit_value), 0);
      chk({tag, "_latch"}, int'(latch), 0);
      chk({tag, "_error"}, int'(error), 0);
   endtask

   initial begin
      logic [23:0] w;
      int bw [6];
      bw[0] = 2; bw[1] = 11; bw[2] = 12; bw[3] = 40; bw[4] = 41; bw[5] = 300;

      fork
         forever begin
            int k;
            bit act;
            @(posedge clk);
            k   = cur_idx;
            act = active && rst_n;
            @(negedge clk);
            if (act) begin
               while (evq.size() > 0 && evq[0].stamp < k) begin
                  checks++;
                  failures++;
                  $display("FAIL missing_event kind=%0d got=absent want_stamp=%0d val=%0h",
                           evq[0].kind, evq[0].stamp, evq[0].val);
                  evq.delete(0);
               end
               if (bit_valid)  take(0, int'(bit_value), k);
               if (data_valid) take(1, int'(data), k);
               if (latch)      take(2, 0, k);
               chk("dout", int'(dout), int'(exp_dout[k]));
               chk("error", int'(error), int'(exp_err[k]));
            end
         end
      join_none

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");

      // nominal word, forwarded word, latch, 10-bit partial then latch, new word
      add_run(1'b0, 5);
      add_std_bits(24'hA5C3F0, 23, 0);
      add_std_bits(24'h123456, 23, 0);
      add_run(1'b0, 130);
      for (int i = 0; i < 10; i++) add_bit(1'($urandom_range(1, 0)), 20, 6, 30);
      add_run(1'b0, 130);
      add_std_bits(24'h5A0FF1, 23, 0);
      add_run(1'b0, 110);
      run_segment();

      // glitches inside a word, 99-vs-100 latch boundary, width boundaries and saturation
      add_run(1'b0, 5);
      w = 24'h3C96E1;
      for (int i = 23; i >= 0; i--) begin
         add_run(1'b1, w[i] ? 20 : 6);
         if (i % 3 == 0) begin
            add_run(1'b0, 4);
            add_run(1'b1, 1);
            add_run(1'b0, 30 - (w[i] ? 20 : 6) - 5);
         end else begin
            add_run(1'b0, 30 - (w[i] ? 20 : 6));
         end
      end
      add_run(1'b0, 110);
      add_run(1'b1, 20);
      add_run(1'b0, 99);
      add_run(1'b1, 1);
      add_run(1'b0, 100);
      for (int i = 0; i < 24; i++) begin
         add_run(1'b1, bw[i % 6]);
         add_run(1'b0, 10);
      end
      add_run(1'b0, 110);
      run_segment();

      // over-long first pulse
      add_run(1'b0, 5);
      add_run(1'b1, 50);
      add_run(1'b0, 10);
      for (int i = 0; i < 23; i++) add_bit(1'($urandom_range(1, 0)), 20, 6, 30);
      add_std_bits(24'h00FFFF, 23, 0);
      add_run(1'b0, 110);
      run_segment();

      // randomized timing words with forwarded traffic
      add_run(1'b0, 5);
      for (int n = 0; n < 3; n++) begin
         add_rand_word(24'($urandom));
         add_rand_word(24'($urandom));
         add_run(1'b0, int'($urandom_range(140, 100)));
      end
      run_segment();

      // reset while forwarding, during the high part of the second word's bit 12
      add_run(1'b0, 5);
      add_std_bits(24'hA5C3F0, 23, 0);
      add_std_bits(24'h123456, 23, 12);
      add_run(1'b1, 8);
      run_segment();
      chk("pre_reset_dout", int'(dout), int'(exp_dout[seg_last]));
      rst_n = 1'b0;
      #1;
      chk_all_zero("mid_reset");

      add_run(1'b0, 5);
      add_std_bits(24'h0F1E2D, 23, 0);
      add_run(1'b0, 110);
      run_segment();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
